// File: rtl/sha256_core_sched.sv
// sha256_core_sched: round-robin scheduler sharing one SHA-256 compression
// core among NUM_REQ requesters. One job at a time is latched and fed to the
// core. The digest, or an error if the watchdog fires first, is then returned
// to the owning requester over a valid/ready response channel.
module sha256_core_sched #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 80
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [NUM_REQ*256-1:0]  req_h_in_i,
  input  logic [NUM_REQ*2048-1:0] req_w_i,
  output logic [NUM_REQ-1:0]      resp_valid_o,
  input  logic [NUM_REQ-1:0]      resp_ready_i,
  output logic [255:0]            resp_hash_o,
  output logic                    resp_err_o,
  output logic                    busy_o,
  output logic                    core_load_o,
  output logic [255:0]            core_h_in_o,
  output logic [2047:0]           core_w_o,
  input  logic                    core_done_i,
  input  logic [255:0]            core_h_out_i
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST   = CW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GRANT_INIT = GW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, last_grant_q;
  logic [GW-1:0]   pick, cand;
  logic            pick_valid;
  logic            accept;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [255:0]    h_q;
  logic [2047:0]   w_q;
  logic [255:0]    hash_q, hash_d;
  logic            err_q, err_d;

  // Round-robin pick: first valid requester after the last one served, wrapping.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(last_grant_q) + k) % NUM_REQ);
      if (!pick_valid && req_valid_i[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
    end
  end

  // Next-state logic plus handshakes; core_done only matters in RUN and wins over the watchdog.
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    req_ready_o  = '0;
    resp_valid_o = '0;
    core_load_o  = 1'b1;
    cnt_d        = cnt_q;
    hash_d       = hash_q;
    err_d        = err_q;
    case (state_q)
      IDLE: begin
        if (pick_valid && !reset_i) begin
          accept            = 1'b1;
          req_ready_o[pick] = 1'b1;
          state_d           = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        core_load_o = 1'b0;
        cnt_d       = cnt_q + 1'b1;
        if (core_done_i) begin
          hash_d  = core_h_out_i;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          hash_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid_o[grant_q] = 1'b1;
        if (resp_ready_i[grant_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, grant bookkeeping, latched job and latched result.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GRANT_INIT;
      cnt_q        <= '0;
      h_q          <= '0;
      w_q          <= '0;
      hash_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hash_q  <= hash_d;
      err_q   <= err_d;
      if (accept) begin
        grant_q      <= pick;
        last_grant_q <= pick;
        h_q          <= req_h_in_i[pick*256 +: 256];
        w_q          <= req_w_i[pick*2048 +: 2048];
      end
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign resp_hash_o = hash_q;
  assign resp_err_o  = err_q;
  assign core_h_in_o = h_q;
  assign core_w_o    = w_q;

endmodule

// File: tb/tb_sha256_core_sched.sv
// tb_sha256_core_sched: drives sha256_core_sched with directed jobs. A
// behavioural SHA-256 core stands in for the real one. A transaction-level
// model predicts the scheduler outputs on every cycle.
module tb_sha256_core_sched;

  localparam int N  = 4;
  localparam int TO = 80;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DIGEST = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [511:0] ABC_BLOCK = {32'h61626380, 448'b0, 32'h00000018};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0]      req_valid, req_ready, resp_valid, resp_ready;
  logic [N*256-1:0]  req_h_in;
  logic [N*2048-1:0] req_w;
  logic [255:0]      resp_hash, core_h_in, core_h_out, coreHash;
  logic [2047:0]     core_w;
  logic              resp_err, busy, core_load, core_done;
  logic              hang = 1'b0;
  logic              donePulse = 1'b0;
  logic [255:0]      reqH [N];
  logic [2047:0]     reqW [N];
  int cycleNo = 0;
  int coreCnt = 0;
  int nChecks = 0;
  int nPass = 0;

  // Model state, owned by the compare process
  int           mBusy = 0, mOwner = 0, mLast = N - 1, mPhase = 0, mRespAt = 0, mGrant = -1;
  logic [255:0] mH, mHash;
  logic [2047:0] mW;
  logic         mErr;
  logic [N-1:0] expReady, expValid;

  sha256_core_sched #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_h_in_i(req_h_in), .req_w_i(req_w),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_hash_o(resp_hash), .resp_err_o(resp_err), .busy_o(busy),
    .core_load_o(core_load), .core_h_in_o(core_h_in), .core_w_o(core_w),
    .core_done_i(core_done), .core_h_out_i(core_h_out));

  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [2047:0] expand(input logic [511:0] blk);
    logic [31:0] wa [64];
    logic [2047:0] o;
    logic [31:0] s0, s1;
    for (int i = 0; i < 16; i++) wa[i] = blk[511-32*i -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(wa[t-15], 7) ^ rotr(wa[t-15], 18) ^ (wa[t-15] >> 3);
      s1 = rotr(wa[t-2], 17) ^ rotr(wa[t-2], 19) ^ (wa[t-2] >> 10);
      wa[t] = s1 + wa[t-7] + s0 + wa[t-16];
    end
    o = '0;
    for (int t = 0; t < 64; t++) o[2047-32*t -: 32] = wa[t];
    return o;
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [2047:0] w);
    logic [31:0] hv [8];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int i = 0; i < 8; i++) hv[i] = hin[255-32*i -: 32];
    a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3];
    e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[2047-32*t -: 32];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + hv[0], b + hv[1], c + hv[2], d + hv[3], e + hv[4], f + hv[5], g + hv[6], h + hv[7]};
  endfunction

  function automatic int arb(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
  endtask

  // Pack the per-requester job tables onto the request buses
  always_comb begin
    req_h_in = '0;
    req_w    = '0;
    for (int r = 0; r < N; r++) begin
      req_h_in[r*256 +: 256] = reqH[r];
      req_w[r*2048 +: 2048]  = reqW[r];
    end
  end

  // Cycle counter used to time accept-to-response latency
  always @(posedge clk) cycleNo <= cycleNo + 1;

  // Behavioural core: counts from 0 after load is released, done from count 65 onwards
  always @(posedge clk) begin
    if (core_load) coreCnt <= 0;
    else if (coreCnt < 127) coreCnt <= coreCnt + 1;
  end

  // Core digest only shows the true value once done, so an early capture is visible
  always_comb coreHash = compress(core_h_in, core_w);
  assign core_done  = donePulse | (!hang && !core_load && coreCnt >= 65);
  assign core_h_out = (!core_load && coreCnt >= 65) ? coreHash : ~coreHash;

  // Per-cycle comparison of DUT outputs against the transaction model, then model advance
  always @(negedge clk) begin
    if (reset) begin
      checkOutput("rst_req_ready", 256'(req_ready), 256'(0));
      checkOutput("rst_resp_valid", 256'(resp_valid), 256'(0));
      checkOutput("rst_busy", 256'(busy), 256'(0));
      checkOutput("rst_core_load", 256'(core_load), 256'(1));
      mBusy = 0;
      mLast = N - 1;
    end else begin
      expReady = '0;
      expValid = '0;
      mGrant   = -1;
      if (mBusy == 0) begin
        mGrant = arb(req_valid, mLast);
        if (mGrant >= 0) expReady[mGrant] = 1'b1;
      end else if (mPhase >= mRespAt) begin
        expValid[mOwner] = 1'b1;
      end
      checkOutput("req_ready", 256'(req_ready), 256'(expReady));
      checkOutput("resp_valid", 256'(resp_valid), 256'(expValid));
      checkOutput("busy", 256'(busy), 256'(mBusy != 0));
      if (mBusy == 0 || mPhase == 1) checkOutput("core_load_hi", 256'(core_load), 256'(1));
      else if (mPhase < mRespAt) checkOutput("core_load_lo", 256'(core_load), 256'(0));
      if (expValid != 0) begin
        checkOutput("resp_hash", resp_hash, mHash);
        checkOutput("resp_err", 256'(resp_err), 256'(mErr));
      end
      if (mBusy != 0) begin
        checkOutput("core_h_in", core_h_in, mH);
        checkOutput("core_w_match", 256'(core_w == mW), 256'(1));
      end
      if (mBusy == 0) begin
        if (mGrant >= 0) begin
          mBusy   = 1;
          mOwner  = mGrant;
          mLast   = mGrant;
          mPhase  = 0;
          mH      = reqH[mGrant];
          mW      = reqW[mGrant];
          mErr    = hang;
          mHash   = hang ? '0 : compress(reqH[mGrant], reqW[mGrant]);
          mRespAt = hang ? TO + 2 : 68;
        end
      end else if (mPhase >= mRespAt && resp_ready[mOwner]) begin
        mBusy = 0;
      end
      if (mBusy != 0) mPhase++;
    end
  end

  task automatic submitJob(input int r, output int tAcc);
    bit got = 0;
    tAcc = -1000;
    req_valid[r] = 1'b1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (req_ready[r]) begin
        got  = 1;
        tAcc = cycleNo;
      end
    end
    if (!got) checkOutput("accept_timeout", 256'(0), 256'(1));
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic waitGrant(output int g);
    g = -1;
    for (int i = 0; i < 300 && g < 0; i++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) if (req_ready[k]) g = k;
    end
    if (g < 0) checkOutput("grant_timeout", 256'(0), 256'(1));
  endtask

  task automatic waitResp(input int r, output int tResp);
    bit got = 0;
    tResp = -1000;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (resp_valid[r]) begin
        got   = 1;
        tResp = cycleNo;
      end
    end
    if (!got) checkOutput("resp_timeout", 256'(0), 256'(1));
  endtask

  task automatic applyStimulus();
    int tA, tR, hc, g;
    int order [6];
    logic [255:0] hash0;
    int expOrder [6] = '{0, 1, 2, 3, 0, 2};

    // Model pins: known "abc" schedule word and digest
    checkOutput("model_w17", 256'(reqW[1][2047-32*17 -: 32]), 256'(32'h000f0000));
    checkOutput("model_abc", compress(IV, reqW[1]), ABC_DIGEST);

    // Reset values of the latched datapath
    #1;
    checkOutput("rst_hash", resp_hash, 256'(0));
    checkOutput("rst_err", 256'(resp_err), 256'(0));
    checkOutput("rst_core_h_in", core_h_in, 256'(0));
    checkOutput("rst_core_w_zero", 256'(core_w == '0), 256'(1));

    // All four requesting from reset: round-robin 0,1,2,3 then 0,2
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int n = 0; n < 6; n++) begin
      if (n == 4) req_valid = 4'b0101;
      waitGrant(g);
      order[n] = g;
      @(posedge clk); #1;
      if (g >= 0) req_valid[g] = 1'b0;
    end
    for (int n = 0; n < 6; n++) checkOutput($sformatf("grant_order%0d", n), 256'(order[n]), 256'(expOrder[n]));
    waitResp(2, tR);
    @(posedge clk); #1;

    // Requester 1 hashes "abc"
    submitJob(1, tA);
    waitResp(1, tR);
    checkOutput("abc_latency", 256'(tR - tA), 256'(68));
    checkOutput("abc_digest", resp_hash, ABC_DIGEST);
    checkOutput("abc_err", 256'(resp_err), 256'(0));
    @(posedge clk); #1;

    // Response back-pressure while requester 3 waits
    resp_ready = 4'b1110;
    submitJob(0, tA);
    waitResp(0, tR);
    hash0 = resp_hash;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      req_valid[3] = 1'b1;
      @(negedge clk);
      checkOutput("hold_valid", 256'(resp_valid), 256'(4'b0001));
      checkOutput("hold_hash", resp_hash, hash0);
      checkOutput("hold_busy", 256'(busy), 256'(1));
      checkOutput("hold_no_ready", 256'(req_ready), 256'(0));
    end
    @(posedge clk); #1;
    resp_ready = 4'b1111;
    @(negedge clk);
    hc = cycleNo;
    checkOutput("hs_no_ready", 256'(req_ready), 256'(0));
    @(negedge clk);
    checkOutput("next_accept", 256'(req_ready), 256'(4'b1000));
    checkOutput("next_accept_cycle", 256'(cycleNo), 256'(hc + 1));
    tA = cycleNo;
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    waitResp(3, tR);
    checkOutput("r3_latency", 256'(tR - tA), 256'(68));
    @(posedge clk); #1;

    // Hung core: watchdog error, then a normal job
    hang = 1'b1;
    submitJob(2, tA);
    waitResp(2, tR);
    checkOutput("hang_latency", 256'(tR - tA), 256'(82));
    checkOutput("hang_err", 256'(resp_err), 256'(1));
    checkOutput("hang_hash", resp_hash, 256'(0));
    @(posedge clk); #1;
    hang = 1'b0;
    submitJob(2, tA);
    waitResp(2, tR);
    checkOutput("after_hang_latency", 256'(tR - tA), 256'(68));
    checkOutput("after_hang_err", 256'(resp_err), 256'(0));
    @(posedge clk); #1;

    // Async reset in the middle of RUN, then resubmit
    submitJob(2, tA);
    repeat (29) @(posedge clk);
    #1;
    checkOutput("abort_cycle", 256'(cycleNo), 256'(tA + 30));
    req_valid[1] = 1'b1;
    reset = 1'b1;
    #1;
    checkOutput("abort_busy", 256'(busy), 256'(0));
    checkOutput("abort_resp_valid", 256'(resp_valid), 256'(0));
    checkOutput("abort_core_load", 256'(core_load), 256'(1));
    checkOutput("abort_req_ready", 256'(req_ready), 256'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    req_valid[1] = 1'b0;
    submitJob(2, tA);
    waitResp(2, tR);
    checkOutput("resubmit_latency", 256'(tR - tA), 256'(68));
    checkOutput("resubmit_hash", resp_hash, compress(reqH[2], reqW[2]));
    @(posedge clk); #1;

    // Spurious core_done in IDLE and in LOAD
    donePulse = 1'b1;
    @(negedge clk);
    checkOutput("idle_pulse_busy", 256'(busy), 256'(0));
    @(posedge clk); #1;
    donePulse = 1'b0;
    submitJob(3, tA);
    donePulse = 1'b1;
    @(negedge clk);
    checkOutput("load_pulse_core_load", 256'(core_load), 256'(1));
    @(posedge clk); #1;
    donePulse = 1'b0;
    waitResp(3, tR);
    checkOutput("pulse_latency", 256'(tR - tA), 256'(68));
    checkOutput("pulse_hash", resp_hash, compress(reqH[3], reqW[3]));
    repeat (3) @(posedge clk);
  endtask

  initial begin
    logic [511:0] blk;
    req_valid  = 4'b1111;
    resp_ready = 4'b1111;
    for (int r = 0; r < N; r++) begin
      for (int i = 0; i < 16; i++) blk[511-32*i -: 32] = 32'hdead0000 + 32'(r * 256 + i);
      reqH[r] = IV ^ {8{32'(r) * 32'h11111111}};
      reqW[r] = expand(blk);
    end
    reqH[1] = IV;
    reqW[1] = expand(ABC_BLOCK);
    applyStimulus();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  // Global bound so a stuck handshake cannot hang the run
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got %0d checks, want completion", nChecks);
    $fatal(1, "[TB] time limit");
  end

endmodule
